// File: rtl/rx_frame_loader.sv
// rx_frame_loader
// Front end of the Viterbi decoder. Received symbols arrive one per beat on a
// valid/ready stream. They are packed MSB-first into traceback-depth words in
// one of two ping-pong banks. Each completed word is handed to the decoder on
// dec_data/dec_en and held there until the decoder pulses dec_done. While one
// bank is being decoded, the other bank fills.
module rx_frame_loader #(
   parameter int WORD_W = 32,  // decoder word width (traceback depth)
   parameter int SYM_W  = 2    // bits per received symbol (radix)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [SYM_W-1:0]  s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic [WORD_W-1:0] dec_data,
   output logic              dec_en,
   input  logic              dec_done,
   output logic [15:0]       frm_cnt,
   output logic              err
);

   // WORD_W is expected to be an exact multiple of SYM_W.
   localparam int NSYM  = WORD_W / SYM_W;
   localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(NSYM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Ping-pong storage and fill-side bookkeeping.
   logic [WORD_W-1:0] bank [2];
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic              fill_ptr;
   logic [CNT_W-1:0]  sym_cnt;

   // Launch side.
   state_t            state;
   logic              rd_ptr;

   // Handshake and event strobes.
   logic              accept;
   logic              close;
   logic              release_bank;
   logic [WORD_W-1:0] wr_word;

   // s_ready depends only on registered state and rst, never on s_valid.
   // It is held low while rst is asserted.
   assign s_ready      = !rst && !full[fill_ptr];
   assign accept       = s_valid && s_ready;
   assign close        = accept && (s_last || (sym_cnt == LAST_SYM));
   assign release_bank = (state == RUN) && dec_done;

   // Build the updated fill-bank word: insert the new symbol at its slot.
   // The word starts from zero on symbol 0 and symbols land in order.
   // Therefore every bit below the newest symbol is still zero.
   // This gives the zero padding of an early s_last close without an
   // explicit mask.
   always_comb begin
      wr_word = (sym_cnt == '0) ? '0 : bank[fill_ptr];
      for (int i = 0; i < NSYM; i++) begin
         if (sym_cnt == CNT_W'(i)) begin
            wr_word[WORD_W-1-i*SYM_W -: SYM_W] = s_data;
         end
      end
   end

   // Next full flags.
   // A release always targets rd_ptr's bank.
   // A close always targets fill_ptr's bank, which cannot be full when
   // accepting.
   // Both events can be honoured in the same cycle.
   always_comb begin
      full_nxt = full;
      if (release_bank) begin
         full_nxt[rd_ptr] = 1'b0;
      end
      if (close) begin
         full_nxt[fill_ptr] = 1'b1;
      end
   end

   // Bank contents: pure data, written on every accepted beat; no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         bank[fill_ptr] <= wr_word;
      end
   end

   // Fill-side control: full flags, fill pointer and symbol position.
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 2'b00;
         fill_ptr <= 1'b0;
         sym_cnt  <= '0;
      end else begin
         full <= full_nxt;
         if (accept) begin
            if (close) begin
               fill_ptr <= !fill_ptr;
               sym_cnt  <= '0;
            end else begin
               sym_cnt  <= sym_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Launch FSM with registered decoder-side outputs, frame count and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rd_ptr   <= 1'b0;
         dec_data <= '0;
         dec_en   <= 1'b0;
         frm_cnt  <= 16'd0;
         err      <= 1'b0;
      end else begin
         // A done pulse outside RUN has no frame to finish; flag it and
         // keep the flag.
         if (dec_done && (state != RUN)) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               // rd_ptr normally already points at the next bank to decode.
               // From reset it is 0, so bank 0 wins a startup tie.
               if (full[rd_ptr]) begin
                  state <= LOAD;
               end else if (full[!rd_ptr]) begin
                  rd_ptr <= !rd_ptr;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               dec_data <= bank[rd_ptr];
               dec_en   <= 1'b1;
               state    <= RUN;
            end
            RUN: begin
               if (dec_done) begin
                  dec_en  <= 1'b0;
                  rd_ptr  <= !rd_ptr;
                  frm_cnt <= frm_cnt + 16'd1;
                  state   <= GAP;
               end
            end
            GAP: begin
               // Guaranteed low cycle on dec_en so the decoder restarts cleanly.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_frame_loader.sv
// Directed self-checking bench for rx_frame_loader.
// The bench acts as both the symbol source and the decoder's done pulse.
module tb_rx_frame_loader;

   localparam int WORD_W = 32;
   localparam int SYM_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic [SYM_W-1:0]  s_data;
   logic              s_last;
   logic              s_ready;
   logic [WORD_W-1:0] dec_data;
   logic              dec_en;
   logic              dec_done;
   logic [15:0]       frm_cnt;
   logic              err;

   int n_cmp = 0;
   int n_err = 0;

   rx_frame_loader #(.WORD_W(WORD_W), .SYM_W(SYM_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .dec_data (dec_data),
      .dec_en   (dec_en),
      .dec_done (dec_done),
      .frm_cnt  (frm_cnt),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Fallback so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted.
   // The wait is bounded; running out of budget shows up as a failed
   // comparison.
   task automatic send_beat(input logic [1:0] d, input logic l);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      n = 0;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      chk("beat_ready", 32'(s_ready), 32'h1);
      tick();
   endtask

   task automatic pulse_done();
      dec_done = 1'b1;
      tick();
      dec_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; dec_done = 1'b0;
      tick();
      tick();
      chk("rst_s_ready",  32'(s_ready),  32'h0);
      chk("rst_dec_en",   32'(dec_en),   32'h0);
      chk("rst_dec_data", dec_data,      32'h0);
      chk("rst_frm_cnt",  32'(frm_cnt),  32'h0);
      chk("rst_err",      32'(err),      32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(s_ready), 32'h1);

      // Full 16-symbol word 0,1,2,3,... -> 0x1B per byte
      for (int i = 0; i < 16; i++) send_beat(2'(i % 4), 1'b0);
      s_valid = 1'b0;
      chk("t1_en_at_close", 32'(dec_en), 32'h0);
      tick();
      chk("t1_en_close_p1", 32'(dec_en), 32'h0);
      tick();
      chk("t1_en_close_p2", 32'(dec_en), 32'h1);
      chk("t1_data",        dec_data,    32'h1B1B1B1B);
      chk("t1_ready",       32'(s_ready), 32'h1);
      pulse_done();
      chk("t1_en_after_done", 32'(dec_en),  32'h0);
      chk("t1_frm_cnt",       32'(frm_cnt), 32'h1);
      tick();
      tick();

      // Short word: 5 x 2'b11, last on the 5th -> zero padded
      for (int i = 0; i < 5; i++) send_beat(2'b11, (i == 4));
      s_valid = 1'b0;
      s_last  = 1'b0;
      tick();
      tick();
      chk("t2_data",    dec_data,    32'hFFC00000);
      chk("t2_en",      32'(dec_en), 32'h1);
      pulse_done();
      chk("t2_frm_cnt", 32'(frm_cnt), 32'h2);
      tick();
      tick();

      // 48-beat stream with dec_done withheld.
      // Words: 0x80000000, 0x55555555, 0xE4E4E4E4.
      for (int i = 0; i < 32; i++)
         send_beat((i == 0) ? 2'b10 : ((i < 16) ? 2'b00 : 2'b01), 1'b0);
      chk("t3_stall_ready",  32'(s_ready), 32'h0);
      tick();
      tick();
      chk("t3_stall_ready2", 32'(s_ready), 32'h0);
      chk("t3_word_a",       dec_data,     32'h80000000);
      chk("t3_word_a_en",    32'(dec_en),  32'h1);
      s_data = 2'b11;                       // beat 33 waiting with s_valid high
      pulse_done();
      chk("t3_ready_after_release", 32'(s_ready), 32'h1);
      chk("t3_frm_cnt_a",           32'(frm_cnt), 32'h3);
      for (int i = 0; i < 16; i++) send_beat(2'(3 - (i % 4)), 1'b0);
      s_valid = 1'b0;
      chk("t3_stall_again", 32'(s_ready), 32'h0);
      chk("t3_word_b",      dec_data,     32'h55555555);
      chk("t3_word_b_en",   32'(dec_en),  32'h1);
      pulse_done();
      chk("t3_frm_cnt_b",   32'(frm_cnt), 32'h4);
      tick();
      tick();
      chk("t3_gap_low",     32'(dec_en),  32'h0);
      tick();
      chk("t3_word_c_en",   32'(dec_en),  32'h1);
      chk("t3_word_c",      dec_data,     32'hE4E4E4E4);
      pulse_done();
      chk("t3_frm_cnt_c",   32'(frm_cnt), 32'h5);
      tick();
      tick();

      // Stray dec_done while idle
      chk("t4_err_before", 32'(err), 32'h0);
      pulse_done();
      chk("t4_err_set",     32'(err),     32'h1);
      chk("t4_frm_cnt_same", 32'(frm_cnt), 32'h5);
      chk("t4_en_idle",     32'(dec_en),  32'h0);
      for (int i = 0; i < 16; i++) send_beat(2'b10, 1'b0);
      s_valid = 1'b0;
      tick();
      tick();
      chk("t4_data",    dec_data,    32'hAAAAAAAA);
      chk("t4_en",      32'(dec_en), 32'h1);
      pulse_done();
      chk("t4_frm_cnt", 32'(frm_cnt), 32'h6);
      chk("t4_err_sticky", 32'(err),  32'h1);
      tick();
      tick();

      // Reset while running with both banks full
      for (int i = 0; i < 32; i++) send_beat((i < 16) ? 2'b11 : 2'b01, 1'b0);
      s_valid = 1'b0;
      chk("t5_both_full_ready", 32'(s_ready), 32'h0);
      chk("t5_running_en",      32'(dec_en),  32'h1);
      chk("t5_running_data",    dec_data,     32'hFFFFFFFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t5_rst_en",      32'(dec_en),  32'h0);
      chk("t5_rst_ready",   32'(s_ready), 32'h1);
      chk("t5_rst_frm_cnt", 32'(frm_cnt), 32'h0);
      chk("t5_rst_err",     32'(err),     32'h0);
      chk("t5_rst_data",    dec_data,     32'h0);
      for (int i = 0; i < 16; i++) send_beat(2'((i + 1) % 4), 1'b0);
      s_valid = 1'b0;
      tick();
      tick();
      chk("t5_fresh_data", dec_data,    32'h6C6C6C6C);
      chk("t5_fresh_en",   32'(dec_en), 32'h1);
      pulse_done();
      chk("t5_frm_cnt",    32'(frm_cnt), 32'h1);
      tick();
      tick();

      // frm_cnt wrap.
      // Preload the count near the top instead of running 65535 frames.
      force dut.frm_cnt = 16'hFFFE;
      tick();
      release dut.frm_cnt;
      tick();
      send_beat(2'b01, 1'b1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      tick();
      tick();
      chk("t6_data_a", dec_data, 32'h40000000);
      pulse_done();
      chk("t6_frm_ffff", 32'(frm_cnt), 32'h0000FFFF);
      tick();
      tick();
      send_beat(2'b10, 1'b1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      tick();
      tick();
      chk("t6_data_b", dec_data, 32'h80000000);
      pulse_done();
      chk("t6_frm_wrap", 32'(frm_cnt), 32'h0);
      chk("t6_en_off",   32'(dec_en),  32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
